packer_arb: RTL and testbench

- Round-robin controller that shares one packer instance (IN_WIDTH→OUT_WIDTH, shift-in-MSB-first, count-based full flag) among NUM_REQ unpacked-word requesters.
- Grants one requester per burst and steers its words into the packer; never writes and reads the packer in the same cycle.
- Zero-pads a short final word; forwards packed words downstream tagged with requester ID and a burst-last flag.
- Sits between the operand fetch streams and the packed-write port of the global buffer.

---
 rtl/packer_arb.sv | 208 ++++++++++++++++++++
 tb/tb_packer_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packer_arb.sv
// packer_arb: round-robin front end that shares a single IN_WIDTH->OUT_WIDTH
// packer among NUM_REQ unpacked-word requesters. Each grant streams words
// from one requester into the packer, zero-pads a short final word and hands
// packed words downstream tagged with the requester ID and a burst-last flag.
// The packer is never written and read in the same cycle.
//
// Ports
//   clk, Reset            clock, synchronous active-high reset
//   Req_EnWr/Last/DatWr   per-requester valid, last marker, data (slice i)
//   Req_RdyWr             per-requester accept (one-hot or zero)
//   Pkr_Reset             packer clear (held while idle)
//   Pkr_EnWr/Pkr_DatWr    packer write strobe / data (zero while padding)
//   Pkr_RdyRd/Pkr_DatRd   packer full flag / packed word
//   Pkr_EnRd              packer read/clear
//   Out_RdyRd/Out_EnRd    downstream valid / take
//   Out_DatRd/Id/Last     packed word, granted requester, last of grant

// Per-requester steering: ready, write handshake and data-mux contribution.
module packer_arb_lane #(
  parameter int IN_WIDTH = 64,
  parameter int ID_W     = 2,
  parameter int LANE_ID  = 0
) (
  input  logic [ID_W-1:0]     gnt,
  input  logic                wr_open,
  input  logic                en_wr,
  input  logic                last,
  input  logic [IN_WIDTH-1:0] dat,
  output logic                rdy,
  output logic                xfer,
  output logic                xfer_last,
  output logic [IN_WIDTH-1:0] dat_sel
);

  logic sel;

  assign sel       = (gnt == ID_W'(LANE_ID));
  assign rdy       = wr_open & sel;
  assign xfer      = rdy & en_wr;
  assign xfer_last = xfer & last;
  // Non-selected lanes contribute zero so the top can OR-reduce.
  assign dat_sel   = sel ? dat : '0;

endmodule

module packer_arb #(
  parameter int NUM_REQ   = 4,
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = 2
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           Req_EnWr,
  input  logic [NUM_REQ-1:0]           Req_Last,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  Req_DatWr,
  output logic [NUM_REQ-1:0]           Req_RdyWr,
  output logic                         Pkr_Reset,
  output logic                         Pkr_EnWr,
  output logic [IN_WIDTH-1:0]          Pkr_DatWr,
  input  logic                         Pkr_RdyRd,
  output logic                         Pkr_EnRd,
  input  logic [OUT_WIDTH-1:0]         Pkr_DatRd,
  output logic                         Out_RdyRd,
  input  logic                         Out_EnRd,
  output logic [OUT_WIDTH-1:0]         Out_DatRd,
  output logic [ID_W-1:0]              Out_Id,
  output logic                         Out_Last
);

  localparam int OUT_NUM_DATA = (OUT_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int FW           = $clog2(OUT_NUM_DATA + 1);
  localparam int WW           = $clog2(BURST_LEN + 1);

  localparam logic [FW-1:0]   FILL_FULL = FW'(OUT_NUM_DATA);
  localparam logic [WW-1:0]   WCNT_LAST = WW'(BURST_LEN - 1);
  localparam logic [ID_W-1:0] ID_MAX    = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state;
  logic [FW-1:0]   fill;
  logic [WW-1:0]   wcnt;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] rr_ptr;
  logic            last_seen;

  logic [FW-1:0]   fill_inc;
  logic            wr_open, wr_xfer, wr_last, rd_xfer;
  logic            pick_vld;
  logic [ID_W-1:0] pick;

  logic [NUM_REQ-1:0][IN_WIDTH-1:0] req_dat;
  logic [NUM_REQ-1:0][IN_WIDTH-1:0] lane_dat;
  logic [NUM_REQ-1:0]               lane_xfer, lane_last;
  logic [IN_WIDTH-1:0]              sel_dat;

  assign req_dat  = Req_DatWr;
  assign fill_inc = fill + 1'b1;

  // Outputs are forced quiet while Reset is high so nothing handshakes in a
  // cycle whose state update is about to be discarded.
  assign wr_open = ~Reset & (state == S_FILL) & (fill < FILL_FULL);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    packer_arb_lane #(
      .IN_WIDTH (IN_WIDTH),
      .ID_W     (ID_W),
      .LANE_ID  (i)
    ) u_lane (
      .gnt       (gnt),
      .wr_open   (wr_open),
      .en_wr     (Req_EnWr[i]),
      .last      (Req_Last[i]),
      .dat       (req_dat[i]),
      .rdy       (Req_RdyWr[i]),
      .xfer      (lane_xfer[i]),
      .xfer_last (lane_last[i]),
      .dat_sel   (lane_dat[i])
    );
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) sel_dat = sel_dat | lane_dat[i];
  end

  assign wr_xfer = |lane_xfer;
  assign wr_last = |lane_last;

  // Round-robin pick: the smallest distance k from rr_ptr wins, so scan k
  // downward and let later (closer) hits overwrite earlier ones.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (Req_EnWr[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          pick_vld = 1'b1;
          pick     = ID_W'(i);
        end
      end
    end
  end

  assign Pkr_Reset = Reset | (state == S_IDLE);
  assign Pkr_EnWr  = wr_xfer | (~Reset & (state == S_PAD));
  assign Pkr_DatWr = (~Reset && state == S_FILL) ? sel_dat : '0;
  assign Out_RdyRd = ~Reset & (state == S_DRAIN) & Pkr_RdyRd;
  assign Out_Last  = ~Reset & (state == S_DRAIN) & (last_seen | (wcnt == WCNT_LAST));
  assign rd_xfer   = Out_RdyRd & Out_EnRd;
  assign Pkr_EnRd  = rd_xfer;
  assign Out_DatRd = Pkr_DatRd;
  assign Out_Id    = gnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      fill      <= '0;
      wcnt      <= '0;
      gnt       <= '0;
      rr_ptr    <= '0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt       <= pick;
            rr_ptr    <= (pick == ID_MAX) ? '0 : pick + 1'b1;
            fill      <= '0;
            wcnt      <= '0;
            last_seen <= 1'b0;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (wr_xfer) begin
            fill <= fill_inc;
            if (wr_last) begin
              last_seen <= 1'b1;
              // Last on a partial word: pad the remaining slots with zero.
              state <= (fill_inc < FILL_FULL) ? S_PAD : S_DRAIN;
            end else if (fill_inc == FILL_FULL) begin
              state <= S_DRAIN;
            end
          end
        end
        S_PAD: begin
          fill <= fill_inc;
          if (fill_inc == FILL_FULL) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (rd_xfer) begin
            fill  <= '0;
            wcnt  <= wcnt + 1'b1;
            state <= Out_Last ? S_IDLE : S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packer_arb.sv
// Bench for packer_arb: emulates the attached packer, drives directed
// requester streams from per-requester queues and compares every cycle
// against a queue-based model of the arbitration/packing rules.
module tb_packer_arb;

  localparam int NUM_REQ = 4;
  localparam int IN      = 64;
  localparam int OUT     = 128;
  localparam int BL      = 2;
  localparam int IDW     = 2;
  localparam int ONUM    = 2;

  logic                       clk = 1'b0;
  logic                       Reset;
  logic [NUM_REQ-1:0]         Req_EnWr, Req_Last, Req_RdyWr;
  logic [NUM_REQ*IN-1:0]      Req_DatWr;
  logic                       Pkr_Reset, Pkr_EnWr, Pkr_RdyRd, Pkr_EnRd;
  logic [IN-1:0]              Pkr_DatWr;
  logic [OUT-1:0]             Pkr_DatRd, Out_DatRd;
  logic                       Out_RdyRd, Out_EnRd, Out_Last;
  logic [IDW-1:0]             Out_Id;
  logic [NUM_REQ-1:0][IN-1:0] dat_in;

  assign Req_DatWr = dat_in;

  always #5 clk = ~clk;

  packer_arb #(
    .NUM_REQ(NUM_REQ), .IN_WIDTH(IN), .OUT_WIDTH(OUT), .BURST_LEN(BL), .ID_W(IDW)
  ) dut (
    .clk(clk), .Reset(Reset),
    .Req_EnWr(Req_EnWr), .Req_Last(Req_Last), .Req_DatWr(Req_DatWr), .Req_RdyWr(Req_RdyWr),
    .Pkr_Reset(Pkr_Reset), .Pkr_EnWr(Pkr_EnWr), .Pkr_DatWr(Pkr_DatWr), .Pkr_RdyRd(Pkr_RdyRd),
    .Pkr_EnRd(Pkr_EnRd), .Pkr_DatRd(Pkr_DatRd),
    .Out_RdyRd(Out_RdyRd), .Out_EnRd(Out_EnRd), .Out_DatRd(Out_DatRd), .Out_Id(Out_Id),
    .Out_Last(Out_Last)
  );

  // Packer emulation: shift in at the LSB end (first word lands in the MSBs),
  // full when ONUM words have been written; read or reset clears it.
  logic [OUT-1:0] pk_dat = '0;
  int             pk_cnt = 0;
  always @(posedge clk) begin
    if (Pkr_Reset || Pkr_EnRd) begin
      pk_dat <= '0;
      pk_cnt <= 0;
    end else if (Pkr_EnWr) begin
      pk_dat <= (pk_dat << IN) | OUT'(Pkr_DatWr);
      pk_cnt <= pk_cnt + 1;
    end
  end
  assign Pkr_RdyRd = (pk_cnt == ONUM);
  assign Pkr_DatRd = pk_dat;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [OUT-1:0] act, input logic [OUT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stimulus: one queue per requester of {last, data}.
  logic [IN:0]        srcq [NUM_REQ][$];
  logic [NUM_REQ-1:0] pop_req = '0;

  // Model state: phase 0 idle, 1 collecting, 2 padding, 3 offering output.
  int             m_ph = 0;
  logic [IDW-1:0] m_g = '0, m_rr = '0;
  int             m_nout = 0;
  bit             m_last = 0;
  logic [IN-1:0]  m_buf[$];
  int             g_log[$];
  logic [OUT-1:0] od_log[$];
  int             oid_log[$];
  bit             olast_log[$];

  always @(negedge clk) begin : cmp
    logic [NUM_REQ-1:0] e_rdy;
    logic               e_pr, e_wr, e_rd, e_ov, e_ol, found;
    logic [IN-1:0]      e_dw;
    logic [OUT-1:0]     e_word;
    logic [IDW-1:0]     j;
    if (Reset) begin
      m_ph = 0; m_g = '0; m_rr = '0; m_nout = 0; m_last = 0;
      m_buf.delete();
      pop_req = '0;
    end else begin
      e_rdy = '0; e_pr = 0; e_wr = 0; e_rd = 0; e_ov = 0; e_ol = 0;
      e_dw = '0; e_word = '0;
      case (m_ph)
        0: e_pr = 1;
        1: begin
          e_rdy[m_g] = 1'b1;
          e_wr = Req_EnWr[m_g];
          e_dw = dat_in[m_g];
        end
        2: e_wr = 1;
        default: begin
          e_ov = 1;
          e_ol = m_last || (m_nout == BL - 1);
          foreach (m_buf[k]) e_word = (e_word << IN) | OUT'(m_buf[k]);
          e_rd = Out_EnRd;
        end
      endcase

      chk("Req_RdyWr", OUT'(Req_RdyWr), OUT'(e_rdy));
      chk("Pkr_Reset", OUT'(Pkr_Reset), OUT'(e_pr));
      chk("Pkr_EnWr",  OUT'(Pkr_EnWr),  OUT'(e_wr));
      if (e_wr) chk("Pkr_DatWr", OUT'(Pkr_DatWr), OUT'(e_dw));
      chk("Pkr_EnRd",  OUT'(Pkr_EnRd),  OUT'(e_rd));
      chk("Out_RdyRd", OUT'(Out_RdyRd), OUT'(e_ov));
      chk("Out_Last",  OUT'(Out_Last),  OUT'(e_ol));
      chk("Out_Id",    OUT'(Out_Id),    OUT'(m_g));
      if (e_ov) chk("Out_DatRd", Out_DatRd, e_word);
      chk("wr_rd_overlap", OUT'(Pkr_EnWr & Pkr_EnRd), OUT'(0));
      checks++;
      assert ($onehot0(Req_RdyWr)) else begin
        errors++;
        $display("FAIL rdy_onehot: got %b required at most one bit", Req_RdyWr);
      end

      // Advance the model by one clock using this cycle's inputs.
      pop_req = '0;
      case (m_ph)
        0: begin
          found = 0;
          for (int k = 0; k < NUM_REQ; k++) begin
            j = IDW'((int'(m_rr) + k) % NUM_REQ);
            if (!found && Req_EnWr[j]) begin
              found = 1;
              m_g = j;
              m_rr = IDW'((int'(j) + 1) % NUM_REQ);
              m_buf.delete();
              m_nout = 0; m_last = 0; m_ph = 1;
              g_log.push_back(int'(j));
            end
          end
        end
        1: if (e_wr) begin
          m_buf.push_back(e_dw);
          pop_req[m_g] = 1'b1;
          if (Req_Last[m_g]) begin
            m_last = 1;
            m_ph = (m_buf.size() < ONUM) ? 2 : 3;
          end else if (m_buf.size() == ONUM) begin
            m_ph = 3;
          end
        end
        2: begin
          m_buf.push_back('0);
          if (m_buf.size() == ONUM) m_ph = 3;
        end
        default: if (e_rd) begin
          od_log.push_back(e_word);
          oid_log.push_back(int'(m_g));
          olast_log.push_back(e_ol);
          m_nout++;
          m_buf.delete();
          m_ph = e_ol ? 0 : 1;
        end
      endcase
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (srcq[i].size() > 0) begin
        Req_EnWr[i] = 1'b1;
        Req_Last[i] = srcq[i][0][IN];
        dat_in[i]   = srcq[i][0][IN-1:0];
      end else begin
        Req_EnWr[i] = 1'b0;
        Req_Last[i] = 1'b0;
        dat_in[i]   = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (pop_req[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic push(input int r, input logic [IN-1:0] d, input bit l);
    srcq[r].push_back({l, d});
  endtask

  task automatic clear_logs();
    g_log.delete(); od_log.delete(); oid_log.delete(); olast_log.delete();
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (srcq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin step(); n++; end while (!(m_ph == 0 && queues_empty()) && n < 300);
    checks++;
    if (n >= 300) begin errors++; $display("FAIL %s: timeout waiting for idle", tag); end
  endtask

  task automatic wait_phase(input int ph, input string tag);
    int n = 0;
    while (m_ph != ph && n < 100) begin step(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL %s: timeout waiting for phase %0d", tag, ph); end
  endtask

  task automatic do_reset(input int cyc);
    Reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
    drive();
    repeat (cyc) step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Out_EnRd = 1'b0;
    drive();
    do_reset(3);
    chk("rst_pkr_reset", OUT'(Pkr_Reset), OUT'(1));
    chk("rst_rdy",       OUT'(Req_RdyWr), OUT'(0));
    chk("rst_out_rdy",   OUT'(Out_RdyRd), OUT'(0));
    step();

    // 1: four words from req 1, last on the fourth -> two packed words.
    clear_logs(); Out_EnRd = 1'b1;
    push(1, 64'h1111111111111111, 0); push(1, 64'h2222222222222222, 0);
    push(1, 64'h3333333333333333, 0); push(1, 64'h4444444444444444, 1);
    drive(); wait_idle("t1");
    chk("t1_cnt",   OUT'(od_log.size()), OUT'(2));
    chk("t1_w0",    od_log[0], 128'h1111111111111111_2222222222222222);
    chk("t1_id0",   OUT'(oid_log[0]), OUT'(1));
    chk("t1_last0", OUT'(olast_log[0]), OUT'(0));
    chk("t1_w1",    od_log[1], 128'h3333333333333333_4444444444444444);
    chk("t1_last1", OUT'(olast_log[1]), OUT'(1));

    // 2: single word with last from req 2 -> one pad cycle.
    clear_logs();
    push(2, 64'hEEEEEEEEEEEEEEEE, 1); drive();
    wait_phase(2, "t2_pad");
    chk("t2_pad_en",  OUT'(Pkr_EnWr), OUT'(1));
    chk("t2_pad_dat", OUT'(Pkr_DatWr), OUT'(0));
    wait_idle("t2");
    chk("t2_w0",    od_log[0], 128'hEEEEEEEEEEEEEEEE_0000000000000000);
    chk("t2_id0",   OUT'(oid_log[0]), OUT'(2));
    chk("t2_last0", OUT'(olast_log[0]), OUT'(1));

    // 4: downstream stalls 5 cycles in drain, then fill resumes.
    clear_logs(); Out_EnRd = 1'b0;
    push(3, 64'hF0, 0); push(3, 64'hF1, 0); push(3, 64'hF2, 0); push(3, 64'hF3, 0);
    drive();
    wait_phase(3, "t4_drain");
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_rdy", OUT'(Out_RdyRd), OUT'(1));
      chk("t4_hold_dat", Out_DatRd, 128'h00000000000000F0_00000000000000F1);
      chk("t4_hold_wr",  OUT'(Pkr_EnWr | (|Req_RdyWr)), OUT'(0));
      step();
    end
    Out_EnRd = 1'b1;
    wait_phase(1, "t4_refill");
    chk("t4_refill_rdy", OUT'(Req_RdyWr), OUT'(4'b1000));
    wait_idle("t4");
    chk("t4_w1",    od_log[1], 128'h00000000000000F2_00000000000000F3);
    chk("t4_last1", OUT'(olast_log[1]), OUT'(1));

    // 3: reqs 0 and 3 stream without last -> burst cap alternates grants.
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      push(0, 64'h3000000000000000 + 64'(k), 0);
      push(3, 64'h3000000000000030 + 64'(k), 0);
    end
    drive(); wait_idle("t3");
    chk("t3_ngnt", OUT'(g_log.size()), OUT'(4));
    chk("t3_g0", OUT'(g_log[0]), OUT'(0));
    chk("t3_g1", OUT'(g_log[1]), OUT'(3));
    chk("t3_g2", OUT'(g_log[2]), OUT'(0));
    chk("t3_g3", OUT'(g_log[3]), OUT'(3));
    chk("t3_nw", OUT'(od_log.size()), OUT'(8));
    chk("t3_w2", od_log[2], 128'h3000000000000030_3000000000000031);
    chk("t3_last3", OUT'(olast_log[3]), OUT'(1));
    chk("t3_last2", OUT'(olast_log[2]), OUT'(0));

    // 5: reset mid-fill after one word, then req 0 beats req 3.
    clear_logs();
    push(2, 64'h5555555555555555, 0); drive();
    wait_phase(1, "t5_fill");
    repeat (4) step();
    chk("t5_stall_rdy", OUT'(Req_RdyWr), OUT'(4'b0100));
    do_reset(1);
    chk("t5_pkr_reset", OUT'(Pkr_Reset), OUT'(1));
    chk("t5_rdy",  OUT'(Req_RdyWr), OUT'(0));
    chk("t5_outs", OUT'({Pkr_EnWr, Pkr_EnRd, Out_RdyRd, Out_Last}), OUT'(0));
    chk("t5_id",   OUT'(Out_Id), OUT'(0));
    chk("t5_dat",  OUT'(Pkr_DatWr), OUT'(0));
    clear_logs();
    push(0, 64'h0A, 1); push(3, 64'h3A, 1); drive();
    wait_idle("t5");
    chk("t5_g0", OUT'(g_log[0]), OUT'(0));
    chk("t5_g1", OUT'(g_log[1]), OUT'(3));

    // 6: all requesters valid after reset -> 0,1,2,3,0.
    do_reset(2);
    clear_logs();
    push(0, 64'h60, 1); push(0, 64'h61, 1);
    push(1, 64'h62, 1); push(2, 64'h63, 1); push(3, 64'h64, 1);
    drive(); wait_idle("t6");
    chk("t6_ngnt", OUT'(g_log.size()), OUT'(5));
    for (int k = 0; k < 5; k++) chk("t6_order", OUT'(g_log[k]), OUT'(k % 4));
    chk("t6_w4", od_log[4], 128'h0000000000000061_0000000000000000);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
